vdp_port: RTL

CPU-side port interface of the MSX VDP: decodes Z80 accesses to I/O ports 0x98 (data) and 0x99 (control), holds VDP registers R0–R7, the 14-bit VRAM address pointer, read-ahead buffer and status register. Drives VRAM port A (write/read strobes, address, data) and supplies the decoded mode, table base addresses, colours and sprite options to the video scan-out stage. Also generates the frame interrupt request from the scan-out stage's frame flag.

---
 rtl/vdp_port.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/vdp_port.sv
// vdp_port: CPU-side port of the MSX VDP.
// Decodes data (0x98) / control (0x99) port accesses, holds R0-R7, the VRAM
// pointer, the read-ahead buffer and the status byte, drives VRAM port A and
// raises the frame interrupt.
// Optional feature macro: VDP_SPRITE_STATUS_EN (latch sprite collision /
// fifth-sprite status bits; when undefined those bits read 0).
module vdp_port #(
  parameter int unsigned VRAM_AW = 14
) (
  input  logic               i_clk,
  input  logic               i_n_reset,
  input  logic               i_port_sel,
  input  logic               i_cpu_wr,
  input  logic               i_cpu_rd,
  input  logic [7:0]         i_cpu_din,
  output logic [7:0]         o_cpu_dout,
  output logic               o_cpu_wait,
  output logic [VRAM_AW-1:0] o_vram_addr,
  output logic [7:0]         o_vram_din,
  output logic               o_vram_wr,
  output logic               o_vram_rd,
  input  logic [7:0]         i_vram_dout,
  input  logic               i_frame_flag,
  input  logic               i_sprite_collision,
  input  logic               i_too_many_sprites,
  input  logic [4:0]         i_sprite5,
  output logic [1:0]         o_mode,
  output logic               o_video_on,
  output logic               o_vert_retrace_int,
  output logic               o_sprite_large,
  output logic               o_sprite_enlarged,
  output logic [13:0]        o_name_table_addr,
  output logic [13:0]        o_color_table_addr,
  output logic [13:0]        o_font_addr,
  output logic [13:0]        o_sprite_attr_addr,
  output logic [13:0]        o_sprite_pattern_table_addr,
  output logic [3:0]         o_text_color,
  output logic [3:0]         o_back_color,
  output logic               o_n_vdp_int
);

  typedef enum logic [1:0] {StIdle, StFetch, StCapture} state_e;

  state_e               r_state, r_state_d;
  logic [7:0]           r_reg [8];
  logic [7:0]           r_reg_d [8];
  logic [7:0]           r_latch, r_latch_d;
  logic                 r_toggle, r_toggle_d;
  logic [VRAM_AW-1:0]   r_ptr, r_ptr_d;
  logic [7:0]           r_rdbuf, r_rdbuf_d;
  logic                 r_f, r_f_d;
  logic                 r_c, r_c_d;
  logic                 r_5s, r_5s_d;
  logic [4:0]           r_num, r_num_d;
  logic                 r_frame_q;
  logic                 r_vram_wr, r_vram_wr_d;
  logic                 r_vram_rd, r_vram_rd_d;
  logic [VRAM_AW-1:0]   r_vram_addr, r_vram_addr_d;
  logic [7:0]           r_vram_din, r_vram_din_d;

  logic                 w_busy;
  logic                 w_data_wr, w_data_rd, w_ctrl_wr, w_stat_rd;
  logic                 w_ctrl_second;
  logic                 w_start;
  logic                 w_frame_rise;
  logic [VRAM_AW-1:0]   w_ptr_load;
  logic [7:0]           w_status;
  logic                 w_g2;

  // Access decode; data-port accesses during a prefetch are dropped.
  assign w_busy        = (r_state != StIdle);
  assign w_data_wr     = i_cpu_wr & ~i_port_sel & ~w_busy;
  assign w_data_rd     = i_cpu_rd & ~i_port_sel & ~w_busy;
  assign w_ctrl_wr     = i_cpu_wr & i_port_sel;
  assign w_stat_rd     = i_cpu_rd & i_port_sel;
  assign w_ctrl_second = w_ctrl_wr & r_toggle;
  assign w_ptr_load    = VRAM_AW'({i_cpu_din[5:0], r_latch});
  assign w_start       = w_data_rd | (w_ctrl_second & ~i_cpu_din[7] & ~i_cpu_din[6]);
  assign w_frame_rise  = i_frame_flag & ~r_frame_q;
  assign w_status      = {r_f, r_5s, r_c, r_num};

  // Prefetch FSM next state; a new request restarts the fetch.
  always_comb begin
    r_state_d = r_state;
    unique case (r_state)
      StIdle:    if (w_start) r_state_d = StFetch;
      StFetch:   r_state_d = w_start ? StFetch : StCapture;
      StCapture: r_state_d = w_start ? StFetch : StIdle;
      default:   r_state_d = StIdle;
    endcase
  end

  // Datapath next state: registers, pointer, buffer, status, VRAM strobes.
  always_comb begin
    r_reg_d       = r_reg;
    r_latch_d     = r_latch;
    r_toggle_d    = r_toggle;
    r_ptr_d       = r_ptr;
    r_rdbuf_d     = r_rdbuf;
    r_f_d         = r_f;
    r_c_d         = r_c;
    r_5s_d        = r_5s;
    r_num_d       = r_num;
    r_vram_wr_d   = 1'b0;
    r_vram_rd_d   = 1'b0;
    r_vram_addr_d = r_vram_addr;
    r_vram_din_d  = r_vram_din;

    if (r_state == StFetch)   r_ptr_d   = r_ptr + VRAM_AW'(1);
    if (r_state == StCapture) r_rdbuf_d = i_vram_dout;

    if (w_data_wr) begin
      r_vram_wr_d   = 1'b1;
      r_vram_addr_d = r_ptr;
      r_vram_din_d  = i_cpu_din;
      r_rdbuf_d     = i_cpu_din;
      r_ptr_d       = r_ptr + VRAM_AW'(1);
      r_toggle_d    = 1'b0;
    end

    if (w_data_rd) begin
      r_vram_rd_d   = 1'b1;
      r_vram_addr_d = r_ptr;
      r_toggle_d    = 1'b0;
    end

    if (w_ctrl_wr) begin
      if (!r_toggle) begin
        r_latch_d  = i_cpu_din;
        r_toggle_d = 1'b1;
      end else begin
        r_toggle_d = 1'b0;
        if (i_cpu_din[7]) begin
          r_reg_d[i_cpu_din[2:0]] = r_latch;
        end else begin
          r_ptr_d = w_ptr_load;
          if (!i_cpu_din[6]) begin
            r_vram_rd_d   = 1'b1;
            r_vram_addr_d = w_ptr_load;
          end
        end
      end
    end

    if (w_stat_rd) begin
      r_toggle_d = 1'b0;
      r_f_d      = 1'b0;
      r_c_d      = 1'b0;
      r_5s_d     = 1'b0;
    end

    // Set after the status-read clear so a coincident event is not lost.
    if (w_frame_rise) r_f_d = 1'b1;
`ifdef VDP_SPRITE_STATUS_EN
    if (i_sprite_collision) r_c_d = 1'b1;
    if (i_too_many_sprites && !r_5s) begin
      r_5s_d  = 1'b1;
      r_num_d = i_sprite5;
    end
`endif
  end

`ifndef VDP_SPRITE_STATUS_EN
  logic w_unused_sprite;
  assign w_unused_sprite = ^{i_sprite_collision, i_too_many_sprites, i_sprite5};
`endif

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_state     <= StIdle;
      for (int i = 0; i < 8; i++) r_reg[i] <= 8'h00;
      r_latch     <= 8'h00;
      r_toggle    <= 1'b0;
      r_ptr       <= '0;
      r_rdbuf     <= 8'h00;
      r_f         <= 1'b0;
      r_c         <= 1'b0;
      r_5s        <= 1'b0;
      r_num       <= 5'd0;
      r_frame_q   <= 1'b0;
      r_vram_wr   <= 1'b0;
      r_vram_rd   <= 1'b0;
      r_vram_addr <= '0;
      r_vram_din  <= 8'h00;
    end else begin
      r_state     <= r_state_d;
      r_reg       <= r_reg_d;
      r_latch     <= r_latch_d;
      r_toggle    <= r_toggle_d;
      r_ptr       <= r_ptr_d;
      r_rdbuf     <= r_rdbuf_d;
      r_f         <= r_f_d;
      r_c         <= r_c_d;
      r_5s        <= r_5s_d;
      r_num       <= r_num_d;
      r_frame_q   <= i_frame_flag;
      r_vram_wr   <= r_vram_wr_d;
      r_vram_rd   <= r_vram_rd_d;
      r_vram_addr <= r_vram_addr_d;
      r_vram_din  <= r_vram_din_d;
    end
  end

  // Register decode to scan-out controls; graphics2 narrows colour/font bases.
  always_comb begin
    if (r_reg[1][4])      o_mode = 2'd0;
    else if (r_reg[0][1]) o_mode = 2'd2;
    else if (r_reg[1][3]) o_mode = 2'd3;
    else                  o_mode = 2'd1;
    w_g2 = (o_mode == 2'd2);
    o_color_table_addr = w_g2 ? {r_reg[3][7], 13'b0} : {r_reg[3], 6'b0};
    o_font_addr        = w_g2 ? {r_reg[4][2], 13'b0} : {r_reg[4][2:0], 11'b0};
  end

  assign o_video_on                  = r_reg[1][6];
  assign o_vert_retrace_int          = r_reg[1][5];
  assign o_sprite_large              = r_reg[1][1];
  assign o_sprite_enlarged           = r_reg[1][0];
  assign o_name_table_addr           = {r_reg[2][3:0], 10'b0};
  assign o_sprite_attr_addr          = {r_reg[5][6:0], 7'b0};
  assign o_sprite_pattern_table_addr = {r_reg[6][2:0], 11'b0};
  assign o_text_color                = r_reg[7][7:4];
  assign o_back_color                = r_reg[7][3:0];
  assign o_n_vdp_int                 = ~(r_f & r_reg[1][5]);

  assign o_cpu_dout  = i_port_sel ? w_status : r_rdbuf;
  assign o_cpu_wait  = w_busy;
  assign o_vram_wr   = r_vram_wr;
  assign o_vram_rd   = r_vram_rd;
  assign o_vram_addr = r_vram_addr;
  assign o_vram_din  = r_vram_din;

  logic w_unused_regs;
  assign w_unused_regs = ^{r_reg[0][7:2], r_reg[0][0], r_reg[1][7], r_reg[1][2],
                           r_reg[2][7:4], r_reg[4][7:3], r_reg[5][7], r_reg[6][7:3]};

endmodule
